// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: register-address default, scoreboard slot
// record and forward-select encoding.
package cpu_pkg;

  localparam int AW_DEFAULT = 5;

  // Slot storage is sized wide enough for any supported AW.
  // Narrower addresses are zero-extended into it.
  localparam int RD_W = 8;

  localparam int FWD_RF = 0;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            we;
    logic            load;
  } slot_t;

endpackage

// File: rtl/hazard_match.sv
// One source port's priority match against the in-flight slots.
// Produces a load-use hazard flag or the forward select for the youngest writer.
module hazard_match
  import cpu_pkg::*;
#(
  parameter int AW       = AW_DEFAULT,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int SW       = $clog2(DEPTH + 1)
) (
  input  logic [AW-1:0]    rs,
  input  slot_t [DEPTH-1:0] slots,
  output logic             hazard,
  output logic [SW-1:0]    fwd_sel
);

  logic [RD_W-1:0] rs_w;

  assign rs_w = RD_W'(rs);

  // Walk oldest to youngest so the youngest match overwrites the result.
  always_comb begin
    hazard  = 1'b0;
    fwd_sel = SW'(FWD_RF);
    if (rs != '0) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (slots[k].valid && slots[k].we && (slots[k].rd == rs_w)) begin
          hazard  = slots[k].load && (k < LOAD_LAT);
          fwd_sel = hazard ? SW'(FWD_RF) : SW'(k + 1);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: tracks in-flight writers after issue,
// selects operand forwarding and stalls ID on load-use or external hold.
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int AW       = AW_DEFAULT,
  parameter int DEPTH    = 3,
  parameter int NRD      = 2,
  parameter int LOAD_LAT = 1,
  parameter int SW       = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_valid_i,
  input  logic [NRD*AW-1:0] issue_rs_i,
  input  logic [AW-1:0]     issue_rd_i,
  input  logic              issue_we_i,
  input  logic              issue_load_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              stall_o,
  output logic [NRD*SW-1:0] fwd_sel_o,
  output logic [15:0]       stall_cnt_o
);

  slot_t [DEPTH-1:0] slots;
  slot_t             issue_slot;
  logic [NRD-1:0]    port_haz;
  logic [NRD*SW-1:0] port_sel;

  for (genvar gp = 0; gp < NRD; gp++) begin : g_port
    hazard_match #(
      .AW      (AW),
      .DEPTH   (DEPTH),
      .LOAD_LAT(LOAD_LAT),
      .SW      (SW)
    ) u_match (
      .rs     (issue_rs_i[gp*AW +: AW]),
      .slots  (slots),
      .hazard (port_haz[gp]),
      .fwd_sel(port_sel[gp*SW +: SW])
    );
  end

  // Outputs are forced quiet while reset is held, independent of slot contents.
  assign stall_o   = rst_i & (hold_i | (issue_valid_i & (|port_haz)));
  assign fwd_sel_o = (rst_i && issue_valid_i) ? port_sel : '0;

  // A flushed or stalled ID instruction enters the chain as a bubble.
  always_comb begin
    issue_slot = '0;
    if (issue_valid_i && !stall_o && !flush_i) begin
      issue_slot.valid = 1'b1;
      issue_slot.rd    = RD_W'(issue_rd_i);
      issue_slot.we    = issue_we_i;
      issue_slot.load  = issue_load_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        slots[k].valid <= 1'b0;
      end
      stall_cnt_o <= 16'h0000;
    end else begin
      if (stall_o && (stall_cnt_o != 16'hFFFF)) begin
        stall_cnt_o <= stall_cnt_o + 16'h0001;
      end
      if (!hold_i) begin
        slots[0] <= issue_slot;
        for (int k = 1; k < DEPTH; k++) begin
          slots[k] <= slots[k-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard against an age-list model,
// run on two instances (LOAD_LAT=1 and LOAD_LAT=2) driven by the same stimulus.
module tb_hazard_scoreboard;

  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int NRD   = 2;
  localparam int SW    = 2;
  localparam int MAXE  = 8;

  logic              clk;
  logic              rst;
  logic              issue_valid;
  logic [NRD*AW-1:0] issue_rs;
  logic [AW-1:0]     issue_rd;
  logic              issue_we;
  logic              issue_load;
  logic              flush;
  logic              hold;

  logic              stall_v [2];
  logic [NRD*SW-1:0] fwd_v   [2];
  logic [15:0]       cnt_v   [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  hazard_scoreboard #(.AW(AW), .DEPTH(DEPTH), .NRD(NRD), .LOAD_LAT(1), .SW(SW)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(issue_valid), .issue_rs_i(issue_rs),
    .issue_rd_i(issue_rd), .issue_we_i(issue_we), .issue_load_i(issue_load),
    .flush_i(flush), .hold_i(hold),
    .stall_o(stall_v[0]), .fwd_sel_o(fwd_v[0]), .stall_cnt_o(cnt_v[0])
  );

  hazard_scoreboard #(.AW(AW), .DEPTH(DEPTH), .NRD(NRD), .LOAD_LAT(2), .SW(SW)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(issue_valid), .issue_rs_i(issue_rs),
    .issue_rd_i(issue_rd), .issue_we_i(issue_we), .issue_load_i(issue_load),
    .flush_i(flush), .hold_i(hold),
    .stall_o(stall_v[1]), .fwd_sel_o(fwd_v[1]), .stall_cnt_o(cnt_v[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: unordered list of issued writers, each tagged with its age
  // (number of pipeline advances since issue, 0 = just issued).
  bit m_live [2][MAXE];
  int m_age  [2][MAXE];
  int m_rd   [2][MAXE];
  bit m_we   [2][MAXE];
  bit m_ld   [2][MAXE];
  int m_cnt  [2];

  function automatic void port_eval(input int u, input int rs, output bit haz, output int sel);
    int best;
    int bi;
    best = DEPTH;
    bi   = 0;
    haz  = 0;
    sel  = 0;
    if (rs != 0) begin
      for (int i = 0; i < MAXE; i++) begin
        if (m_live[u][i] && m_we[u][i] && m_rd[u][i] == rs && m_age[u][i] < best) begin
          best = m_age[u][i];
          bi   = i;
        end
      end
      if (best < DEPTH) begin
        if (m_ld[u][bi] && best < u + 1) haz = 1;
        else sel = best + 1;
      end
    end
  endfunction

  function automatic bit exp_stall(input int u);
    bit h;
    int s;
    bit any;
    any = 0;
    for (int p = 0; p < NRD; p++) begin
      port_eval(u, int'(issue_rs[p*AW +: AW]), h, s);
      any = any | h;
    end
    if (!rst) return 1'b0;
    if (hold) return 1'b1;
    return issue_valid && any;
  endfunction

  function automatic logic [NRD*SW-1:0] exp_fwd(input int u);
    logic [NRD*SW-1:0] r;
    bit h;
    int s;
    r = '0;
    if (rst && issue_valid) begin
      for (int p = 0; p < NRD; p++) begin
        port_eval(u, int'(issue_rs[p*AW +: AW]), h, s);
        r[p*SW +: SW] = SW'(s);
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h want %0h at %0t", name, u, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      bit st;
      st = exp_stall(u);
      if (!rst) begin
        for (int i = 0; i < MAXE; i++) m_live[u][i] = 0;
        m_cnt[u] = 0;
      end else begin
        if (st && m_cnt[u] < 65535) m_cnt[u]++;
        if (!hold) begin
          for (int i = 0; i < MAXE; i++) begin
            if (m_live[u][i]) begin
              m_age[u][i]++;
              if (m_age[u][i] >= DEPTH) m_live[u][i] = 0;
            end
          end
          if (issue_valid && !st && !flush) begin
            for (int i = 0; i < MAXE; i++) begin
              if (!m_live[u][i]) begin
                m_live[u][i] = 1;
                m_age[u][i]  = 0;
                m_rd[u][i]   = int'(issue_rd);
                m_we[u][i]   = issue_we;
                m_ld[u][i]   = issue_load;
                break;
              end
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        chk("stall", u, 32'(stall_v[u]), 32'(exp_stall(u)));
        chk("fwd_sel", u, 32'(fwd_v[u]), 32'(exp_fwd(u)));
        chk("stall_cnt", u, 32'(cnt_v[u]), 32'(m_cnt[u]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input bit v, input int rs0, input int rs1, input int rd, input bit we, input bit ld);
    issue_valid = v;
    issue_rs    = {AW'(rs1), AW'(rs0)};
    issue_rd    = AW'(rd);
    issue_we    = we;
    issue_load  = ld;
    flush       = 1'b0;
    hold        = 1'b0;
  endtask

  task automatic do_reset();
    set_ins(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk_en = 1;
  endtask

  initial begin
    rst = 1'b0;
    set_ins(0, 0, 0, 0, 0, 0);
    cyc();
    do_reset();
    #1;
    chk("reset_stall", 0, 32'(stall_v[0]), 32'd0);
    chk("reset_cnt", 1, 32'(cnt_v[1]), 32'd0);

    // add r3 ; sub r4,r3,r1
    do_reset();
    set_ins(1, 0, 0, 3, 1, 0);
    cyc();
    set_ins(1, 3, 1, 4, 1, 0);
    #1;
    chk("alu_stall", 0, 32'(stall_v[0]), 32'd0);
    chk("alu_fwd", 0, 32'(fwd_v[0]), 32'h1);
    chk("alu_fwd", 1, 32'(fwd_v[1]), 32'h1);

    // lw r2 ; add r5,r2,r2
    do_reset();
    set_ins(1, 0, 0, 2, 1, 1);
    cyc();
    set_ins(1, 2, 2, 5, 1, 0);
    #1;
    chk("lu_stall_c1", 0, 32'(stall_v[0]), 32'd1);
    chk("lu_stall_c1", 1, 32'(stall_v[1]), 32'd1);
    cyc();
    #1;
    chk("lu_stall_c2", 0, 32'(stall_v[0]), 32'd0);
    chk("lu_fwd_c2", 0, 32'(fwd_v[0]), 32'hA);
    chk("lu_cnt_c2", 0, 32'(cnt_v[0]), 32'd1);
    chk("lu_stall_c2", 1, 32'(stall_v[1]), 32'd1);
    cyc();
    #1;
    chk("lu_stall_c3", 1, 32'(stall_v[1]), 32'd0);
    chk("lu_fwd_c3", 1, 32'(fwd_v[1]), 32'hF);
    chk("lu_cnt_c3", 1, 32'(cnt_v[1]), 32'd2);

    // r0 writer then r0 reader; r7 in slots 0 and 2
    do_reset();
    set_ins(1, 0, 0, 0, 1, 0);
    cyc();
    set_ins(1, 0, 0, 6, 1, 0);
    #1;
    chk("r0_fwd", 0, 32'(fwd_v[0]), 32'h0);
    chk("r0_stall", 0, 32'(stall_v[0]), 32'd0);
    do_reset();
    set_ins(1, 0, 0, 7, 1, 0);
    cyc();
    set_ins(0, 0, 0, 0, 0, 0);
    cyc();
    set_ins(1, 0, 0, 7, 1, 0);
    cyc();
    set_ins(1, 7, 0, 9, 1, 0);
    #1;
    chk("young_fwd", 0, 32'(fwd_v[0]), 32'h1);
    chk("young_fwd", 1, 32'(fwd_v[1]), 32'h1);

    // hold for 3 cycles with a load in slot 0, then flush during load-use stall
    do_reset();
    set_ins(1, 0, 0, 2, 1, 1);
    cyc();
    set_ins(1, 2, 0, 5, 1, 0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_stall", 0, 32'(stall_v[0]), 32'd1);
      cyc();
    end
    hold  = 1'b0;
    flush = 1'b1;
    #1;
    chk("hold_lu_stall", 0, 32'(stall_v[0]), 32'd1);
    chk("hold_cnt", 0, 32'(cnt_v[0]), 32'd3);
    cyc();
    flush = 1'b0;
    #1;
    chk("flush_stall", 0, 32'(stall_v[0]), 32'd0);
    chk("flush_fwd", 0, 32'(fwd_v[0]), 32'h2);
    chk("flush_cnt", 0, 32'(cnt_v[0]), 32'd4);
    chk("flush_stall", 1, 32'(stall_v[1]), 32'd1);

    // reset pulse in the middle of a 2-cycle load stall
    do_reset();
    set_ins(1, 0, 0, 2, 1, 1);
    cyc();
    set_ins(1, 2, 2, 5, 1, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_hold_stall", 1, 32'(stall_v[1]), 32'd0);
    chk("rst_hold_fwd", 1, 32'(fwd_v[1]), 32'h0);
    cyc();
    rst = 1'b1;
    #1;
    chk("post_rst_stall", 1, 32'(stall_v[1]), 32'd0);
    chk("post_rst_fwd", 1, 32'(fwd_v[1]), 32'h0);
    chk("post_rst_fwd", 0, 32'(fwd_v[0]), 32'h0);
    chk("post_rst_cnt", 1, 32'(cnt_v[1]), 32'd0);

    // randomized traffic
    do_reset();
    repeat (3000) begin
      cyc();
      rst         = ($urandom_range(0, 99) != 0);
      issue_valid = ($urandom_range(0, 9) < 8);
      issue_rs    = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
      issue_rd    = AW'($urandom_range(0, 3));
      issue_we    = ($urandom_range(0, 9) < 7);
      issue_load  = ($urandom_range(0, 9) < 3);
      flush       = ($urandom_range(0, 9) == 0);
      hold        = ($urandom_range(0, 99) < 8);
    end

    // counter saturation under a long hold
    do_reset();
    hold = 1'b1;
    repeat (65540) cyc();
    #1;
    chk("cnt_sat", 0, 32'(cnt_v[0]), 32'hFFFF);
    chk("cnt_sat", 1, 32'(cnt_v[1]), 32'hFFFF);

    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter AW, default 5, giving the register-address width.
REQ-002 The block SHALL have parameter DEPTH, default 3, giving the number of tracked in-flight slots after issue (EX, MEM, WB).
REQ-003 The block SHALL have parameter NRD, default 2, giving the number of source-operand read ports.
REQ-004 The block SHALL have parameter LOAD_LAT, default 1, giving the lowest slot index (range 0..DEPTH-1) from which load data is forwardable.
REQ-005 The block SHALL have parameter SW, default $clog2(DEPTH+1), giving the forward-select width.
REQ-006 clk_i input 1: the single clock; all state updates on its rising edge.
REQ-007 rst_i input 1: synchronous reset, active-low.
REQ-008 issue_valid_i input 1: an instruction is presented in ID this cycle.
REQ-009 issue_rs_i input NRD*AW: source register addresses; port p occupies bits [p*AW +: AW].
REQ-010 issue_rd_i input AW: destination register of the issuing instruction.
REQ-011 issue_we_i input 1: the issuing instruction writes the register file.
REQ-012 issue_load_i input 1: the issuing instruction is a load.
REQ-013 flush_i input 1: kill the instruction in ID (taken branch or jump).
REQ-014 hold_i input 1: external freeze, such as multi-cycle memory.
REQ-015 stall_o output 1: PC and IF/ID SHALL hold; ID/EX receives a bubble.
REQ-016 fwd_sel_o output NRD*SW: per-port operand source; 0 = register file, k = result of slot k-1.
REQ-017 stall_cnt_o output 16: saturating count of stall cycles.

Function
REQ-018 State SHALL be DEPTH slots, each holding {valid, rd, we, load}; slot k holds the instruction issued k+1 cycles earlier, absent stalls.
REQ-019 Each edge with hold_i=0, slot[k] SHALL load slot[k-1] for k>=1.
REQ-020 On the same edge, slot[0] SHALL load the issue fields if issue_valid_i=1, stall_o=0 and flush_i=0; otherwise slot[0] SHALL load a bubble (valid=0).
REQ-021 When hold_i=1, all slots SHALL hold their values and stall_o SHALL be 1.
REQ-022 Per port p, a match SHALL require: rs_p != 0, slot valid=1, slot we=1, and slot rd == rs_p.
REQ-023 Writes to r0 SHALL never match.
REQ-024 Per port, the youngest matching slot (lowest k) SHALL win.
REQ-025 If the winner has load=1 and k < LOAD_LAT, the port SHALL raise a load-use hazard.
REQ-026 Otherwise the port's fwd_sel SHALL be k+1.
REQ-027 If no slot matches, the port's fwd_sel SHALL be 0.
REQ-028 stall_o SHALL equal hold_i OR (issue_valid_i AND any port hazard); it is combinational from inputs and slots, with zero latency.
REQ-029 fwd_sel_o SHALL be combinational, valid whenever issue_valid_i=1, and 0 otherwise.
REQ-030 flush_i and stall_o in the same cycle: the flush SHALL take priority and the ID instruction SHALL NOT be issued.
REQ-031 A load-use stall SHALL repeat each cycle until the producing load reaches slot LOAD_LAT; with LOAD_LAT=L and the producer in slot 0, the stall lasts L cycles.
REQ-032 stall_cnt_o SHALL increment on every edge where stall_o=1, and SHALL saturate at 16'hFFFF.

Reset
REQ-033 On an edge with rst_i=0, all slot valid bits SHALL clear and stall_cnt_o SHALL become 0.
REQ-034 While rst_i=0, stall_o SHALL be 0 and fwd_sel_o SHALL be all 0, regardless of other inputs.
REQ-035 Reset asserted mid-stall SHALL discard all in-flight slots; the first cycle after release SHALL see an empty scoreboard.

Structure
REQ-036 The AW default, the slot record type, and the fwd_sel encoding constants (FWD_RF=0) SHALL reside in the shared package cpu_pkg.
REQ-037 The per-port priority match and hazard decision SHALL be one sub-module, hazard_match, instantiated NRD times; the slot register chain and counter SHALL stay in the top module.

Verification
REQ-038 Back-to-back ALU ops add r3 then sub r4,r3,r1 (defaults) -> stall_o=0, port0 fwd_sel=1 for one cycle.
REQ-039 lw r2 followed immediately by add r5,r2,r2 with LOAD_LAT=1 -> stall_o=1 for exactly 1 cycle, then both ports fwd_sel=2, stall_cnt_o=1.
REQ-040 Same sequence with LOAD_LAT=2 -> stall_o=1 for 2 cycles, then fwd_sel=3 on both ports.
REQ-041 Writer to r0 followed by a reader of r0 -> fwd_sel=0 and stall_o=0; and r7 written by slots 0 and 2 at once -> fwd_sel=1 (youngest wins).
REQ-042 hold_i=1 for 3 cycles with a load in slot 0 -> slots frozen, stall_o=1 for 3 cycles, stall_cnt_o+=3; flush_i=1 during a load-use stall -> slot 0 becomes a bubble next cycle.
REQ-043 rst_i=0 for one edge during a 2-cycle load stall -> next cycle stall_o=0, all fwd_sel=0, stall_cnt_o=0.
